// File: rtl/lu_hit_gen_pkg.sv
// Shared sizes, FSM state encodings and helpers for the lookup hit generator.
// Widths here must track the candidate accumulator that consumes hit_o.
package lu_hit_gen_pkg;

  localparam int LANES        = 4;
  localparam int LU_BUS_SZ    = LANES;
  localparam int ENTRY_W      = 8;
  localparam int ENTRY_SZ     = ENTRY_W;
  localparam int ADDR_W       = 4;
  localparam int LU_ADDR_SZ   = ADDR_W;
  localparam int CNT_W        = 7;
  localparam int CANDIDATE_SZ = 7;
  localparam int LANE_W       = $clog2(LANES);
  localparam int WORD_W       = ADDR_W + 1;
  localparam int MAX_ENT      = LANES * (2 ** ADDR_W);

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_DRN  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef struct packed {
    logic [ENTRY_W-1:0] query;
    logic [ENTRY_W-1:0] mask;
    logic [CNT_W-1:0]   num_ent;
    logic [WORD_W-1:0]  words;
  } cfg_t;

  // Oversized counts are clamped so the word address can never wrap.
  function automatic logic [CNT_W-1:0] sat_ent(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_ENT)) ? CNT_W'(MAX_ENT) : n;
  endfunction

  function automatic logic [WORD_W-1:0] word_cnt(input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] s;
    s = n + CNT_W'(LANES - 1);
    return s[CNT_W-1:LANE_W];
  endfunction

endpackage

// File: rtl/lu_hit_gen_lane_cmp.sv
// Single-lane masked compare: a lane hits when every masked bit of the entry
// equals the query and the lane holds a valid table entry.
module lu_hit_gen_lane_cmp
  import lu_hit_gen_pkg::*;
(
  input  logic [ENTRY_W-1:0] entry_i,
  input  logic [ENTRY_W-1:0] query_i,
  input  logic [ENTRY_W-1:0] mask_i,
  input  logic               lane_vld_i,
  output logic               hit_o
);

  assign hit_o = lane_vld_i && (((entry_i ^ query_i) & mask_i) == '0);

endmodule

// File: rtl/lu_hit_gen.sv
// Table scan front end: sequences reads of the packed entry table, compares each
// lane against the latched query/mask and feeds registered hits to the accumulator.
module lu_hit_gen
  import lu_hit_gen_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ENTRY_W-1:0]       query_i,
  input  logic [ENTRY_W-1:0]       mask_i,
  input  logic [CNT_W-1:0]         num_ent_i,
  output logic                     mem_rd_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [LANES*ENTRY_W-1:0] mem_data_i,
  output logic [LANES-1:0]         hit_o,
  output logic                     acc_en_o,
  output logic                     acc_clear_o,
  output logic                     busy_o,
  output logic                     done_o
);

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [WORD_W-1:0] wcnt_q, wcnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [LANES-1:0]  lane_vld_q, lane_vld_d;
  logic [LANES-1:0]  hit_q, hit_d;
  logic              acc_en_q, acc_en_d;
  logic [LANES-1:0]  lane_hit;
  logic              rd_en;
  logic              last_word;

  assign rd_en     = (state_q == S_RD);
  assign last_word = (wcnt_q == cfg_q.words - 1'b1);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d       = S_CLR;
          cfg_d.query   = query_i;
          cfg_d.mask    = mask_i;
          cfg_d.num_ent = sat_ent(num_ent_i);
          cfg_d.words   = word_cnt(sat_ent(num_ent_i));
          wcnt_d        = '0;
        end
      end
      S_CLR:  state_d = (cfg_q.num_ent != '0) ? S_RD : S_WAIT;
      S_RD: begin
        wcnt_d = wcnt_q + 1'b1;
        if (last_word) state_d = S_DRN;
      end
      // Leave drain once the final word has moved from the data stage into hit_q.
      S_DRN:  if (!rd_vld_q) state_d = S_WAIT;
      S_WAIT: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane validity travels alongside the read so it lines up with returning data.
  always_comb begin
    rd_vld_d = rd_en;
    for (int k = 0; k < LANES; k++) begin
      lane_vld_d[k] = rd_en && ({wcnt_q, LANE_W'(k)} < cfg_q.num_ent);
    end
    hit_d    = rd_vld_q ? lane_hit : '0;
    acc_en_d = rd_vld_q;
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      lu_hit_gen_lane_cmp u_cmp (
        .entry_i    (mem_data_i[gi*ENTRY_W +: ENTRY_W]),
        .query_i    (cfg_q.query),
        .mask_i     (cfg_q.mask),
        .lane_vld_i (lane_vld_q[gi]),
        .hit_o      (lane_hit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      wcnt_q     <= '0;
      rd_vld_q   <= 1'b0;
      lane_vld_q <= '0;
      hit_q      <= '0;
      acc_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wcnt_q     <= wcnt_d;
      rd_vld_q   <= rd_vld_d;
      lane_vld_q <= lane_vld_d;
      hit_q      <= hit_d;
      acc_en_q   <= acc_en_d;
    end
  end

  assign mem_rd_o    = rd_en;
  assign mem_addr_o  = rd_en ? wcnt_q[ADDR_W-1:0] : '0;
  assign hit_o       = hit_q;
  assign acc_en_o    = acc_en_q;
  assign acc_clear_o = (state_q == S_CLR);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_lu_hit_gen.sv
// Bench for lu_hit_gen: behavioural table memory and accumulator around the DUT,
// directed and random scans checked against a count/hit model derived from the entry table.
module tb_lu_hit_gen;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  query_i;
  logic [7:0]  mask_i;
  logic [6:0]  num_ent_i;
  logic        mem_rd_o;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_data_i;
  logic [3:0]  hit_o;
  logic        acc_en_o;
  logic        acc_clear_o;
  logic        busy_o;
  logic        done_o;

  logic [7:0]  tbl [64];
  logic [6:0]  acc_cnt;
  int          nvec;
  int          nerr;

  lu_hit_gen dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .query_i     (query_i),
    .mask_i      (mask_i),
    .num_ent_i   (num_ent_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .hit_o       (hit_o),
    .acc_en_o    (acc_en_o),
    .acc_clear_o (acc_clear_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read table memory: word a holds entries 4a..4a+3, lane k in bits [8k +: 8].
  always @(posedge clk) begin
    if (mem_rd_o) begin
      for (int k = 0; k < 4; k++) mem_data_i[k*8 +: 8] <= tbl[{mem_addr_o, 2'(k)}];
    end
  end

  // Candidate accumulator.
  always @(posedge clk) begin
    if (rst_i || acc_clear_o) acc_cnt <= '0;
    else if (acc_en_o)        acc_cnt <= acc_cnt + 7'($countones(hit_o));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input int nsat, input logic [7:0] q, input logic [7:0] m);
    int c;
    c = 0;
    for (int i = 0; i < nsat; i++) if (((tbl[i] ^ q) & m) == 8'h00) c++;
    return c;
  endfunction

  function automatic logic [3:0] ref_hit(input int w, input int nsat, input logic [7:0] q,
                                         input logic [7:0] m);
    logic [3:0] h;
    h = '0;
    for (int k = 0; k < 4; k++) begin
      if ((w*4 + k) < nsat && ((tbl[w*4 + k] ^ q) & m) == 8'h00) h[k] = 1'b1;
    end
    return h;
  endfunction

  // Called at a negedge with the DUT idle; drives start and follows the scan to done.
  task automatic run_scan(input logic [6:0] n, input logic [7:0] q, input logic [7:0] m,
                          input bit hold);
    int nsat, words, exp_cnt, rd_cnt, en_cnt, clr_cnt, last_en_k, done_k;
    nsat    = (int'(n) > 64) ? 64 : int'(n);
    words   = (nsat + 3) / 4;
    exp_cnt = ref_count(nsat, q, m);
    rd_cnt = 0; en_cnt = 0; clr_cnt = 0; last_en_k = 0; done_k = 0;
    chk("idle_before", {31'd0, busy_o}, 0);
    start_i = 1'b1; query_i = q; mask_i = m; num_ent_i = n;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("clr_first", {31'd0, acc_clear_o}, 1);
        if (!hold) begin
          start_i   = 1'b0;
          query_i   = 8'($urandom);
          mask_i    = 8'($urandom);
          num_ent_i = 7'($urandom);
        end
      end
      chk("busy", {31'd0, busy_o}, 1);
      chk("clr_en_overlap", {31'd0, acc_clear_o & acc_en_o}, 0);
      if (acc_clear_o) clr_cnt++;
      if (mem_rd_o) begin
        chk("rd_addr", {28'd0, mem_addr_o}, rd_cnt);
        if (rd_cnt == 0) chk("rd_first_cycle", k, 2);
        rd_cnt++;
      end
      if (acc_en_o) begin
        chk("hit", {28'd0, hit_o}, {28'd0, ref_hit(en_cnt, nsat, q, m)});
        en_cnt++;
        last_en_k = k;
      end else begin
        chk("hit_idle", {28'd0, hit_o}, 0);
      end
      if (done_o) done_k = k;
    end
    chk("done_cycle", done_k, (words == 0) ? 3 : words + 5);
    chk("rd_count", rd_cnt, words);
    chk("en_count", en_cnt, words);
    chk("clr_count", clr_cnt, 1);
    if (words > 0) chk("done_after_en", done_k - last_en_k, 2);
    chk("acc_count", {25'd0, acc_cnt}, exp_cnt);
    $display("scan n=%0d q=%02h m=%02h: reads=%0d count=%0d expected=%0d done@%0d",
             n, q, m, rd_cnt, acc_cnt, exp_cnt, done_k);
    @(negedge clk);
    chk("idle_after", {31'd0, busy_o}, 0);
    chk("done_pulse", {31'd0, done_o}, 0);
  endtask

  initial begin
    int ndone, nbusy;
    logic [7:0] q, m;
    nvec = 0; nerr = 0;
    rst_i = 1'b1; start_i = 1'b0; query_i = '0; mask_i = '0; num_ent_i = '0;
    mem_data_i = '0;
    for (int i = 0; i < 64; i++) tbl[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {22'd0, mem_rd_o, mem_addr_o, hit_o, acc_en_o, acc_clear_o, busy_o},
        0);
    chk("rst_done", {31'd0, done_o}, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // Three exact matches in a 16-entry table.
    for (int i = 0; i < 64; i++) begin
      tbl[i] = 8'($urandom);
      if (tbl[i] == 8'h5A) tbl[i] = 8'h00;
    end
    tbl[3] = 8'h5A; tbl[7] = 8'h5A; tbl[12] = 8'h5A;
    run_scan(7'd16, 8'h5A, 8'hFF, 1'b0);

    // Mask 0 matches every valid entry; tail lanes of the last word must stay low.
    for (int i = 0; i < 64; i++) tbl[i] = 8'h5A;
    run_scan(7'd6, 8'h00, 8'h00, 1'b0);
    run_scan(7'd0, 8'h5A, 8'hFF, 1'b0);
    run_scan(7'd64, 8'h50, 8'hF0, 1'b0);
    run_scan(7'd100, 8'h50, 8'hF0, 1'b0);

    // Reset during the third read aborts the scan silently.
    start_i = 1'b1; query_i = 8'h50; mask_i = 8'hF0; num_ent_i = 7'd64;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    chk("rst_mid_rd", {27'd0, mem_rd_o, mem_addr_o}, {27'd0, 1'b1, 4'd2});
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs",
        {21'd0, mem_rd_o, mem_addr_o, hit_o, acc_en_o, acc_clear_o, busy_o, done_o}, 0);
    rst_i = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o) ndone++;
      if (busy_o) nbusy++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_stays_idle", nbusy, 0);
    run_scan(7'd13, 8'h5A, 8'hFF, 1'b0);

    // Start held through a scan: exactly one re-accept after DONE.
    for (int i = 0; i < 64; i++) tbl[i] = (i % 3 == 0) ? 8'hC3 : 8'($urandom);
    run_scan(7'd30, 8'hC3, 8'hFF, 1'b1);
    run_scan(7'd30, 8'hC3, 8'hFF, 1'b0);

    for (int r = 0; r < 12; r++) begin
      q = 8'($urandom);
      for (int i = 0; i < 64; i++) tbl[i] = ($urandom_range(0, 1) == 0) ? q : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      run_scan(7'($urandom_range(0, 127)), q, m, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
